// File: rtl/tt_um_param_counter.sv
// rtl/tt_um_param_counter.sv - WIDTH-bit prescaled up/down counter with wrap, one-shot and bounce modes
module tt_um_param_counter #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cnt_en,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] div_sel,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               done,
    output logic               blink,
    output logic               oe
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               done_q, done_d;
    logic               dir_q, dir_d;
    logic               tick;
    logic               eff_dir;
    logic               bounce_dir;
    logic [WIDTH-1:0]   count_up, count_dn;

    // Bounce uses the latched direction; other modes follow the live pin.
    assign eff_dir  = (mode == MODE_BOUNCE) ? dir_q : dir;
    assign tc       = eff_dir ? (count_q == COUNT_MAX) : (count_q == '0);
    assign count_up = count_q + WIDTH'(1);
    assign count_dn = count_q - WIDTH'(1);

    assign bounce_dir = tc ? ~dir_q : dir_q;

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        done_d  = done_q;
        dir_d   = dir_q;
        tick    = 1'b0;
        if (ena) begin
            if (load) begin
                count_d = load_val;
                presc_d = '0;
                done_d  = 1'b0;
                dir_d   = dir;
            end else if (cnt_en) begin
                // Equality compare: a div_sel lowered below presc waits for the wrap.
                if (presc_q == div_sel) begin
                    presc_d = '0;
                    tick    = 1'b1;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            if (tick) begin
                case (mode)
                    MODE_WRAP: begin
                        count_d = dir ? count_up : count_dn;
                    end
                    MODE_ONESHOT: begin
                        if (!done_q) begin
                            if (tc) begin
                                done_d = 1'b1;
                            end else begin
                                count_d = dir ? count_up : count_dn;
                            end
                        end
                    end
                    MODE_BOUNCE: begin
                        dir_d   = bounce_dir;
                        count_d = bounce_dir ? count_up : count_dn;
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign blink = count_q[WIDTH-1];
    assign oe    = ena & ~done_q;

endmodule

// File: tb/tb_tt_um_param_counter.sv
// tb/tb_tt_um_param_counter.sv - directed and randomized checks of tt_um_param_counter against a reference model
module tb_tt_um_param_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cnt_en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] div_sel;
    logic [7:0] count;
    logic       tc;
    logic       done;
    logic       blink;
    logic       oe;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state kept as plain integers.
    int m_count;
    int m_presc;
    bit m_done;
    bit m_dirq;

    tt_um_param_counter #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .cnt_en  (cnt_en),
        .dir     (dir),
        .mode    (mode),
        .load    (load),
        .load_val(load_val),
        .div_sel (div_sel),
        .count   (count),
        .tc      (tc),
        .done    (done),
        .blink   (blink),
        .oe      (oe)
    );

    always #5 clk = ~clk;

    function automatic bit model_tc();
        bit up;
        up = (mode == 2'd2) ? m_dirq : dir;
        return up ? (m_count == 255) : (m_count == 0);
    endfunction

    function automatic void model_edge();
        bit t;
        bit fire;
        t = model_tc();
        if (!rst_n) begin
            m_count = 0; m_presc = 0; m_done = 0; m_dirq = 1;
        end else if (!ena) begin
            // frozen
        end else if (load) begin
            m_count = int'(load_val); m_presc = 0; m_done = 0; m_dirq = dir;
        end else if (cnt_en) begin
            fire    = (m_presc == int'(div_sel));
            m_presc = fire ? 0 : (m_presc + 1) % 16;
            if (fire) begin
                case (mode)
                    2'd0: m_count = (m_count + (dir ? 1 : 255)) % 256;
                    2'd1: begin
                        if (!m_done) begin
                            if (t) m_done = 1;
                            else   m_count = (m_count + (dir ? 1 : 255)) % 256;
                        end
                    end
                    2'd2: begin
                        if (t) m_dirq = !m_dirq;
                        m_count = (m_count + (m_dirq ? 1 : 255)) % 256;
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1; ena = 1; cnt_en = 0; dir = 1; mode = 2'd0;
        load = 0; load_val = 8'h00; div_sel = 4'd0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n  = 0;
        cnt_en = 1;
        step();
        step();
        n_total++;
        if ({count, done, tc, blink, oe} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset: count=%0d done=%b tc=%b blink=%b oe=%b, want 0 0 0 0 1",
                     count, done, tc, blink, oe);
        end else n_pass++;
        rst_n = 1;
    endtask

    task automatic test_wrap();
        int tc_cycles;
        int tc_at;
        int blink_rise_at;
        bit prev_blink;
        int bad;
        rst_n = 0; step(); set_idle();
        cnt_en = 1; dir = 1; mode = 2'd0; div_sel = 4'd0;
        tc_cycles = 0; tc_at = -1; blink_rise_at = -1; prev_blink = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (count !== 8'((i + 1) % 256)) bad++;
            if (tc === 1'b1) begin tc_cycles++; tc_at = int'(count); end
            if (blink === 1'b1 && !prev_blink && blink_rise_at < 0) blink_rise_at = int'(count);
            prev_blink = blink;
        end
        n_total++;
        if (bad != 0 || count !== 8'd0) begin
            $display("FAIL wrap_count: %0d bad cycles, final count=%0d, want 0 bad and 0", bad, count);
        end else n_pass++;
        n_total++;
        if (tc_cycles != 1 || tc_at != 255) begin
            $display("FAIL wrap_tc: high %0d cycles at %0d, want 1 cycle at 255", tc_cycles, tc_at);
        end else n_pass++;
        n_total++;
        if (blink_rise_at != 128) begin
            $display("FAIL wrap_blink: rose at %0d, want 128", blink_rise_at);
        end else n_pass++;
    endtask

    task automatic test_prescale();
        rst_n = 0; step(); set_idle();
        cnt_en = 1; div_sel = 4'd3;
        for (int i = 0; i < 12; i++) step();
        n_total++;
        if (count !== 8'd3) $display("FAIL presc_12: count=%0d want 3", count);
        else n_pass++;
        step(); step();
        cnt_en = 0;
        for (int i = 0; i < 5; i++) step();
        n_total++;
        if (count !== 8'd3) $display("FAIL presc_frozen: count=%0d want 3", count);
        else n_pass++;
        cnt_en = 1;
        step();
        n_total++;
        if (count !== 8'd3) $display("FAIL presc_resume1: count=%0d want 3", count);
        else n_pass++;
        step();
        n_total++;
        if (count !== 8'd4) $display("FAIL presc_resume2: count=%0d want 4", count);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [7:0] seen [5];
        int hold_bad;
        set_idle();
        mode = 2'd1; dir = 0; cnt_en = 1; div_sel = 4'd0;
        load = 1; load_val = 8'd5; step(); load = 0;
        for (int i = 0; i < 5; i++) begin step(); seen[i] = count; end
        n_total++;
        if ({seen[0], seen[1], seen[2], seen[3], seen[4]} !== {8'd4, 8'd3, 8'd2, 8'd1, 8'd0})
            $display("FAIL oneshot_seq: %0d %0d %0d %0d %0d want 4 3 2 1 0",
                     seen[0], seen[1], seen[2], seen[3], seen[4]);
        else n_pass++;
        step();
        n_total++;
        if ({done, oe} !== 2'b10) $display("FAIL oneshot_done: done=%b oe=%b want 1 0", done, oe);
        else n_pass++;
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            dir = 1'($urandom);
            step();
            if (count !== 8'd0 || done !== 1'b1 || oe !== 1'b0) hold_bad++;
        end
        dir = 0;
        n_total++;
        if (hold_bad != 0) $display("FAIL oneshot_hold: %0d bad cycles want 0", hold_bad);
        else n_pass++;
        load = 1; load_val = 8'd9; step(); load = 0;
        n_total++;
        if ({count, done, oe} !== {8'd9, 1'b0, 1'b1})
            $display("FAIL oneshot_reload: count=%0d done=%b oe=%b want 9 0 1", count, done, oe);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int bad;
        set_idle();
        mode = 2'd2; dir = 1; cnt_en = 1; div_sel = 4'd0;
        load = 1; load_val = 8'd253; step(); load = 0;
        dir = 0;
        step(); step();
        n_total++;
        if ({count, tc} !== {8'd255, 1'b1}) $display("FAIL bounce_top: count=%0d tc=%b want 255 1", count, tc);
        else n_pass++;
        bad = 0;
        for (int v = 254; v >= 0; v--) begin
            step();
            if (count !== 8'(v)) bad++;
        end
        n_total++;
        if (bad != 0 || tc !== 1'b1) $display("FAIL bounce_down: %0d bad, tc=%b at count=%0d want 0 bad tc 1", bad, tc, count);
        else n_pass++;
        step();
        n_total++;
        if ({count, tc} !== {8'd1, 1'b0}) $display("FAIL bounce_bottom: count=%0d tc=%b want 1 0", count, tc);
        else n_pass++;
    endtask

    task automatic test_priority();
        set_idle();
        mode = 2'd0; dir = 1; cnt_en = 1; div_sel = 4'd0;
        load = 1; load_val = 8'h40; step(); load = 0; div_sel = 4'd1;
        n_total++;
        if (count !== 8'h40) $display("FAIL load_over_tick: count=%0d want 64", count);
        else n_pass++;
        step();
        n_total++;
        if (count !== 8'h40) $display("FAIL load_presc_clear: count=%0d want 64", count);
        else n_pass++;
        step();
        n_total++;
        if (count !== 8'h41) $display("FAIL load_first_tick: count=%0d want 65", count);
        else n_pass++;
        ena = 0; load = 1; load_val = 8'h99;
        for (int i = 0; i < 4; i++) step();
        n_total++;
        if ({count, oe} !== {8'h41, 1'b0}) $display("FAIL ena_freeze: count=%0d oe=%b want 65 0", count, oe);
        else n_pass++;
        rst_n = 0; step();
        n_total++;
        if (count !== 8'd0) $display("FAIL reset_while_disabled: count=%0d want 0", count);
        else n_pass++;
        ena = 1; step();
        n_total++;
        if (count !== 8'd0) $display("FAIL reset_over_load: count=%0d want 0", count);
        else n_pass++;
        rst_n = 1; load = 0;
    endtask

    task automatic test_random();
        int bad;
        int first_bad;
        bad = 0; first_bad = -1;
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            ena      = ($urandom_range(0, 9) != 0);
            cnt_en   = ($urandom_range(0, 4) != 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = 8'($urandom);
            dir      = ($urandom_range(0, 7) != 0) ? dir : ~dir;
            mode     = ($urandom_range(0, 49) == 0) ? 2'($urandom) : mode;
            div_sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            step();
            if ({count, done, tc, blink, oe} !==
                {8'(m_count), m_done, model_tc(), 8'(m_count) >= 8'd128, ena & ~m_done}) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL random_model: %0d mismatching cycles (first at %0d), want 0", bad, first_bad);
        else n_pass++;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_wrap();
        test_prescale();
        test_oneshot();
        test_bounce();
        test_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
